// File: rtl/iterative_shift_unit_pkg.sv
// Shared types for the iterative shift unit: operation encoding and FSM states.
package shift_unit_pkg;

    // Operation encoding as presented by the control unit.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_RSV = 2'b01,
        SH_SRL = 2'b10,
        SH_SRA = 2'b11
    } shift_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shift_state_e;

endpackage

// File: rtl/iterative_shift_unit_shift_step.sv
// One combinational shift step of k bits.
// The arithmetic right shift takes its fill from an explicit bit rather than
// from value[WIDTH-1], so repeated steps keep extending the original sign.
module shift_step
    import shift_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] k,
    input  logic [WIDTH-1:0]   value,
    input  logic               fill,
    output logic [WIDTH-1:0]   shifted
);

    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] ext_sra;

    // Select the shift flavour; SRA shifts a fill-extended copy so vacated bits take the fill bit.
    always_comb begin
        ext     = {fill, value};
        ext_sra = ext >>> k;
        shifted = value;
        case (shift_op_e'(op))
            SH_SLL:  shifted = value << k;
            SH_SRL:  shifted = value >> k;
            SH_SRA:  shifted = ext_sra[WIDTH-1:0];
            default: shifted = value;
        endcase
    end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle variable shifter (SLL/SRL/SRA) with request and result
// valid/ready handshakes. Shifts at most STEP bits per cycle.
module iterative_shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy
);

    shift_state_e       state;
    shift_state_e       next_state;
    shift_op_e          op_q;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] k;
    logic [SHAMT_W-1:0] rem_next;
    logic               fill;
    logic               accept;
    logic [WIDTH-1:0]   shifted;

    // Step size this cycle: the full STEP unless fewer bits remain.
    always_comb begin
        k = SHAMT_W'(STEP);
        if (int'(rem) < STEP) begin
            k = rem;
        end
        rem_next = rem - k;
    end

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .op      (op_q),
        .k       (k),
        .value   (result),
        .fill    (fill),
        .shifted (shifted)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state   = state;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                accept      = start_valid;
                if (start_valid) begin
                    if (shamt == '0 || shift_op_e'(op) == SH_RSV) begin
                        next_state = DONE;
                    end else begin
                        next_state = SHIFT;
                    end
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (rem_next == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (result_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture on accept, then one step per SHIFT cycle; held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            rem    <= '0;
            op_q   <= SH_SLL;
            fill   <= 1'b0;
        end else if (accept) begin
            result <= data_in;
            rem    <= shamt;
            op_q   <= shift_op_e'(op);
            fill   <= data_in[WIDTH-1];
        end else if (state == SHIFT) begin
            result <= shifted;
            rem    <= rem_next;
        end
    end

endmodule
